// File: rtl/inport_pkg.sv
// Shared definitions for the mesh router input port: output-port indices,
// FSM states and the XY dimension-order routing function.
package inport_pkg;

   localparam int NUM_PORTS = 5;
   localparam int P_LOCAL   = 0;
   localparam int P_NORTH   = 1;
   localparam int P_EAST    = 2;
   localparam int P_SOUTH   = 3;
   localparam int P_WEST    = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQUEST  = 2'd1,
      TRANSFER = 2'd2
   } state_t;

   // X is resolved fully before Y, which keeps the mesh deadlock-free.
   function automatic logic [NUM_PORTS-1:0] xy_route(input logic [31:0] dx,
                                                     input logic [31:0] dy,
                                                     input logic [31:0] lx,
                                                     input logic [31:0] ly);
      logic [NUM_PORTS-1:0] r;
      r = '0;
      if (dx > lx)      r[P_EAST]  = 1'b1;
      else if (dx < lx) r[P_WEST]  = 1'b1;
      else if (dy > ly) r[P_SOUTH] = 1'b1;
      else if (dy < ly) r[P_NORTH] = 1'b1;
      else              r[P_LOCAL] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: the oldest entry is always on rd_data while
// not empty. Writes while full are dropped unless a read frees the slot.
module fifo_fwft #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_rd;
   logic             do_wr;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full && !do_rd) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/inport_xy.sv
// Mesh router input port: FWFT flit buffer, credit return, and an XY route
// request held for a whole wormhole packet until its tail is forwarded.
module inport_xy
   import inport_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int X_W        = 4,
   parameter int Y_W        = 4,
   parameter int LOCAL_X    = 0,
   parameter int LOCAL_Y    = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_tail,
   output logic                         credit_out,
   input  logic                         arb_ack,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_tail,
   output logic [NUM_PORTS-1:0]         port_rqs,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         err_overflow,
   output state_t                       state_dbg
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t                 state;
   logic [DATA_WIDTH:0]    head;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   deq;
   logic [X_W-1:0]         dest_x;
   logic [Y_W-1:0]         dest_y;
   logic [NUM_PORTS-1:0]   head_route;

   fifo_fwft #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (in_valid),
      .wr_data  ({in_tail, in_data}),
      .rd_en    (deq),
      .rd_data  (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .overflow (err_overflow)
   );

   assign out_tail  = head[DATA_WIDTH];
   assign out_data  = head[DATA_WIDTH-1:0];
   assign dest_x    = head[DATA_WIDTH-1 -: X_W];
   assign dest_y    = head[DATA_WIDTH-1-X_W -: Y_W];
   assign state_dbg = state;

   assign head_route = xy_route(32'(dest_x), 32'(dest_y), 32'(LOCAL_X), 32'(LOCAL_Y));

   // Handshake: a flit moves to the crossbar on a cycle where out_valid and
   // out_ready are both high; out_valid never depends on out_ready.
   assign out_valid = (state == TRANSFER) && !fifo_empty;
   assign deq       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         port_rqs   <= '0;
         credit_out <= 1'b0;
      end else begin
         credit_out <= deq;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state    <= REQUEST;
                  port_rqs <= head_route;
               end
            end
            REQUEST: begin
               if (arb_ack) state <= TRANSFER;
            end
            TRANSFER: begin
               if (deq && out_tail) begin
                  state    <= IDLE;
                  port_rqs <= '0;
               end
            end
            default: begin
               state    <= IDLE;
               port_rqs <= '0;
            end
         endcase
      end
   end

   a_full_count: assert property (@(posedge clk) disable iff (!rst)
      fifo_full |-> (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_inport_xy.sv
// Bench for inport_xy at router (1,1): routing vector table, hand-written
// packet sequences, and randomized traffic against a flit-level model.
module tb_inport_xy;
   import inport_pkg::*;

   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int LX = 1;
   localparam int LY = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_tail = 1'b0;
   logic          credit_out;
   logic          arb_ack = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_tail;
   logic [4:0]    port_rqs;
   logic [2:0]    fifo_count;
   logic          err_overflow;
   state_t        state_dbg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         x;
      int         y;
      logic [4:0] exp_rqs;
   } route_vec_t;

   route_vec_t vecs[7];
   logic [DW:0] exp_q[$];
   logic [DW:0] gen_q[$];

   inport_xy #(
      .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .X_W (4), .Y_W (4),
      .LOCAL_X (LX), .LOCAL_Y (LY)
   ) dut (
      .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
      .in_tail (in_tail), .credit_out (credit_out), .arb_ack (arb_ack),
      .out_ready (out_ready), .out_valid (out_valid), .out_data (out_data),
      .out_tail (out_tail), .port_rqs (port_rqs), .fifo_count (fifo_count),
      .err_overflow (err_overflow), .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ref_route(input int x, input int y);
      if (x > LX) return 5'b00100;
      if (x < LX) return 5'b10000;
      if (y > LY) return 5'b01000;
      if (y < LY) return 5'b00010;
      return 5'b00001;
   endfunction

   function automatic logic [DW-1:0] mk(input int x, input int y, input logic [23:0] p);
      logic [3:0] xx;
      logic [3:0] yy;
      xx = 4'(x);
      yy = 4'(y);
      return {xx, yy, p};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_flit(input logic [DW-1:0] d, input logic t);
      in_valid = 1'b1;
      in_data  = d;
      in_tail  = t;
      tick();
      in_valid = 1'b0;
      in_tail  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'b0; in_tail = 1'b0; in_data = '0;
      arb_ack = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rqs"},    port_rqs, 0);
      check({tag, "_valid"},  out_valid, 0);
      check({tag, "_credit"}, credit_out, 0);
      check({tag, "_count"},  fifo_count, 0);
      check({tag, "_ovf"},    err_overflow, 0);
   endtask

   initial begin
      logic [DW-1:0] f [6];
      logic [DW:0]   e;
      logic [3:0]    rdy_pat;
      int            credit_seen;
      int            credits;
      logic [4:0]    cur_rqs;
      logic          deq_prev;
      logic          tail_deq_prev;
      int            cyc;

      vecs[0] = '{3, 1, 5'b00100};
      vecs[1] = '{1, 1, 5'b00001};
      vecs[2] = '{0, 1, 5'b10000};
      vecs[3] = '{1, 0, 5'b00010};
      vecs[4] = '{1, 2, 5'b01000};
      vecs[5] = '{0, 3, 5'b10000};
      vecs[6] = '{2, 0, 5'b00100};

      do_reset();
      check_idle_outputs("reset");

      // Single-flit packets: request one cycle after the write is visible.
      for (int i = 0; i < 7; i++) begin
         f[0] = mk(vecs[i].x, vecs[i].y, 24'(32'h100 + i));
         push_flit(f[0], 1'b1);
         check("rqs_early", port_rqs, 0);
         check("count_one", fifo_count, 1);
         tick();
         check("route_vec", port_rqs, vecs[i].exp_rqs);
         check("req_valid", out_valid, 0);
         arb_ack = 1'b1;
         tick();
         arb_ack = 1'b0;
         check("xfer_valid", out_valid, 1);
         check("xfer_data", out_data, f[0]);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         check("single_credit", credit_out, 1);
         check("single_rqs_clr", port_rqs, 0);
         check("single_count", fifo_count, 0);
         tick();
         check("credit_pulse_end", credit_out, 0);
      end

      // Three-flit packet to (1,0) with out_ready toggling.
      f[0] = mk(1, 0, 24'h0000a1);
      f[1] = 32'hb0b0_0001;
      f[2] = 32'hc0c0_0002;
      push_flit(f[0], 1'b0);
      push_flit(f[1], 1'b0);
      push_flit(f[2], 1'b1);
      check("pkt3_rqs", port_rqs, 5'b00010);
      arb_ack = 1'b1;
      tick();
      arb_ack = 1'b0;
      rdy_pat = 4'b1101;
      credit_seen = 0;
      begin
         int k;
         k = 0;
         for (int c = 0; c < 4; c++) begin
            check("pkt3_hold", port_rqs, 5'b00010);
            out_ready = rdy_pat[c];
            if (out_ready) begin
               check("pkt3_data", out_data, f[k]);
               check("pkt3_tail", out_tail, (k == 2));
               k++;
            end
            tick();
            if (credit_out) credit_seen++;
         end
      end
      out_ready = 1'b0;
      check("pkt3_rqs_clr", port_rqs, 0);
      tick();
      if (credit_out) credit_seen++;
      check("pkt3_credits", credit_seen, 3);

      // Body starvation: head leaves, body arrives five cycles later.
      f[0] = mk(3, 2, 24'h0000d1);
      f[1] = 32'he0e0_0003;
      push_flit(f[0], 1'b0);
      tick();
      check("starve_rqs", port_rqs, 5'b00100);
      arb_ack = 1'b1;
      tick();
      arb_ack = 1'b0;
      out_ready = 1'b1;
      check("starve_head", out_data, f[0]);
      tick();
      for (int c = 0; c < 5; c++) begin
         check("starve_valid", out_valid, 0);
         check("starve_hold", port_rqs, 5'b00100);
         check("starve_state", state_dbg, TRANSFER);
         tick();
      end
      push_flit(f[1], 1'b1);
      check("resume_valid", out_valid, 1);
      check("resume_data", out_data, f[1]);
      tick();
      out_ready = 1'b0;
      check("resume_rqs_clr", port_rqs, 0);

      // Overflow: five writes with no grant, then read+write while full.
      for (int i = 0; i < 6; i++) f[i] = mk(3, 3, 24'(32'h300 + i));
      for (int i = 0; i < 5; i++) push_flit(f[i], 1'b0);
      check("ovf_count", fifo_count, 4);
      check("ovf_flag", err_overflow, 1);
      check("ovf_head", out_data, f[0]);
      arb_ack = 1'b1;
      tick();
      arb_ack = 1'b0;
      in_valid = 1'b1; in_data = f[5]; in_tail = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_tail = 1'b0;
      check("rw_full_count", fifo_count, 4);
      check("rw_full_flag", err_overflow, 1);
      for (int i = 0; i < 4; i++) begin
         e = (i == 3) ? {1'b1, f[5]} : {1'b0, f[i+1]};
         check("ovf_drain_data", out_data, e[DW-1:0]);
         check("ovf_drain_tail", out_tail, e[DW]);
         tick();
      end
      out_ready = 1'b0;
      check("ovf_drain_count", fifo_count, 0);
      check("ovf_rqs_clr", port_rqs, 0);
      do_reset();
      check("ovf_cleared", err_overflow, 0);

      // Asynchronous reset in the middle of a packet.
      push_flit(mk(2, 1, 24'h0000f1), 1'b0);
      push_flit(32'hf0f0_0002, 1'b0);
      arb_ack = 1'b1;
      tick();
      arb_ack = 1'b0;
      check("mid_state", state_dbg, TRANSFER);
      #3 rst = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      @(posedge clk);
      #1 rst = 1'b1;
      f[0] = mk(0, 2, 24'h0000f9);
      push_flit(f[0], 1'b1);
      tick();
      check("post_rst_route", port_rqs, 5'b10000);
      arb_ack = 1'b1;
      tick();
      arb_ack = 1'b0;
      check("post_rst_data", out_data, f[0]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_rst_clr", port_rqs, 0);

      // Randomized traffic with credit-respecting upstream.
      do_reset();
      for (int p = 0; p < 40; p++) begin
         int len;
         len = $urandom_range(1, 4);
         for (int j = 0; j < len; j++) begin
            if (j == 0)
               e = {(len == 1), mk($urandom_range(0, 3), $urandom_range(0, 3), 24'($urandom))};
            else
               e = {(j == len - 1), 32'($urandom)};
            gen_q.push_back(e);
         end
      end
      credits = DEPTH;
      cur_rqs = '0;
      deq_prev = 1'b0;
      tail_deq_prev = 1'b0;
      cyc = 0;
      while ((gen_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
         if (tail_deq_prev) begin
            check("rnd_rqs_drop", port_rqs, 0);
            cur_rqs = '0;
         end else if (cur_rqs != 0) begin
            check("rnd_rqs_hold", port_rqs, cur_rqs);
         end else if (port_rqs != 0) begin
            if (exp_q.size() == 0) begin
               check("rnd_rqs_spurious", port_rqs, 0);
            end else begin
               cur_rqs = ref_route(int'(exp_q[0][31:28]), int'(exp_q[0][27:24]));
               check("rnd_route", port_rqs, cur_rqs);
            end
         end
         check("rnd_count", fifo_count, exp_q.size());
         check("rnd_credit", credit_out, deq_prev);
         if (credit_out) credits++;
         if (out_valid && port_rqs == 0) check("rnd_valid_gate", out_valid, 0);

         out_ready = ($urandom_range(0, 3) != 0);
         arb_ack   = (port_rqs != 0) && ($urandom_range(0, 1) == 1);
         deq_prev = out_valid && out_ready;
         tail_deq_prev = 1'b0;
         if (deq_prev) begin
            e = exp_q.pop_front();
            check("rnd_data", out_data, e[DW-1:0]);
            check("rnd_tail", out_tail, e[DW]);
            tail_deq_prev = e[DW];
         end
         in_valid = 1'b0;
         if (credits > 0 && gen_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            e = gen_q.pop_front();
            in_valid = 1'b1;
            in_data  = e[DW-1:0];
            in_tail  = e[DW];
            credits--;
            exp_q.push_back(e);
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0; arb_ack = 1'b0;
      check("rnd_drain", exp_q.size() + gen_q.size(), 0);
      check("rnd_credit_last", credit_out, deq_prev);
      if (credit_out) credits++;
      check("rnd_credits_back", credits, DEPTH);
      check("rnd_no_ovf", err_overflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
